uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Buffered UART transmitter: accepts bytes over a valid/wait handshake into an
//  internal FIFO and serialises them LSB-first on a single line (start, 8 data,
//  optional parity, 1 or 2 stop bits). It is the host-bound counterpart of the
//  OLED-control UART receive path. It lets bursty producers (status/log dumps)
//  queue up to FIFO_DEPTH bytes without stalling on each frame.
// PARAMETERS
//  PULSEW      434  clocks per bit (115200 bps @ 50 MHz); legal range >= 2
//  FIFO_AW     4    FIFO address width; depth = 2**FIFO_AW = 16 entries
//  PARITY      0    0 = none, 1 = odd, 2 = even
//  STOP_BITS   1    stop bits per frame, 1 or 2
// PORTS
//  clk     in   1          system clock
//  srst    in   1          synchronous reset, active-high
//  datai   in   8          byte to transmit
//  validi  in   1          datai valid
//  waiti   out  1          1 = push refused this cycle (FIFO full or reset recovery)
//  uarto   out  1          serial line, idle high
//  level   out  FIFO_AW+1  bytes currently queued (excludes byte on the line)
//  busy    out  1          1 while a frame is on the line (start through last stop)
// BEHAVIOUR
//  Reset (srst=1 at posedge): uarto=1, busy=0, level=0, waiti=1, FIFO emptied,
//   FSM->IDLE, bit timer=0. waiti stays 1 through the first cycle after srst
//   deasserts, then reflects the full flag.
//  Push: byte accepted on posedge where validi=1 && waiti=0. waiti is a register
//   output (level==DEPTH or reset recovery); it never depends on validi.
//   Full + pop in same cycle: push still refused (waiti already 1); next cycle waiti=0.
//  Pop: FSM pops FIFO head only in IDLE with level>0; push and pop in the same
//   cycle both take effect, level unchanged.
//  FSM states / transitions (each bit lasts exactly PULSEW clocks):
//   IDLE   : uarto=1; level>0 -> pop, load shifter, uarto=0, -> START
//   START  : after PULSEW clks -> uarto=data[0], -> DATA (bit idx 0)
//   DATA   : each PULSEW clks shift next bit; after bit 7 -> PARITY if PARITY!=0,
//            else -> STOP
//   PARITY : uarto = ^data (even) or ~^data (odd) over the 8 data bits; PULSEW clks -> STOP
//   STOP   : uarto=1 for STOP_BITS*PULSEW clks -> IDLE
//  Latency: byte pushed into empty FIFO at posedge N -> uarto falls after posedge N+1.
//  Back-to-back: next start bit begins the cycle after the last stop bit ends
//   (IDLE occupies one clock); no extra gap.
//  Frame length = (10 + (PARITY!=0) + (STOP_BITS-1)) * PULSEW clocks (+1 IDLE clk).
//  busy=1 from the cycle uarto first drops until the cycle the FSM returns to IDLE.
//  level: FIFO_AW+1 bits, wraps never; pointers wrap modulo DEPTH.
//  srst mid-frame: frame truncated, uarto=1 next cycle, queued bytes discarded.
//  validi while waiti=1: ignored, datai not sampled; producer must hold.
// TESTING (bench uses PULSEW=4 unless noted)
//  1. Push 0x55 into idle block -> uarto: 0 at N+1, then 1,0,1,0,1,0,1,0, stop 1;
//     every bit 4 clks; busy high 40 clks.
//  2. Push 16 bytes back-to-back while line is busy -> level=16, waiti=1; 17th
//     validi held -> accepted only after first pop; all 17 bytes appear in order.
//  3. PARITY=2: send 0x03 -> parity bit 0; 0x07 -> 1. PARITY=1: 0x07 -> 0.
//  4. STOP_BITS=2: two queued bytes -> stop high 8 clks, next start bit after 1 IDLE clk.
//  5. srst asserted at data bit 3 with 5 bytes queued -> next cycle uarto=1,
//     level=0, busy=0, waiti=1 for one cycle after release; no further frames.
//  6. Push and pop in same cycle with level=3 -> level stays 3; data order intact.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter.
// Bytes enter through a valid/wait handshake and are sent LSB-first on uarto.
// Each frame is a start bit, 8 data bits, an optional parity bit, then 1 or 2
// stop bits. Every bit lasts PULSEW clocks.
module uart_tx_fifo #(
   parameter int PULSEW    = 434,
   parameter int FIFO_AW   = 4,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic               clk,
   input  logic               srst,
   input  logic [7:0]         datai,
   input  logic               validi,
   output logic               waiti,
   output logic               uarto,
   output logic [FIFO_AW:0]   level,
   output logic               busy
);

   localparam int DEPTH = 2**FIFO_AW;
   // The timer must reach the longest single phase, which is the stop period.
   localparam int TW    = $clog2(STOP_BITS*PULSEW);
   localparam logic [TW-1:0]    BIT_LAST  = TW'(PULSEW-1);
   localparam logic [TW-1:0]    STOP_LAST = TW'(STOP_BITS*PULSEW-1);
   localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // FIFO storage and control
   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q;
   logic [FIFO_AW-1:0] rd_ptr_q;
   logic [FIFO_AW:0]   level_q;
   logic [FIFO_AW:0]   level_d;
   logic               waiti_q;
   logic               recov_q;
   logic               push;
   logic               pop;
   logic [7:0]         head;

   // Transmit FSM state
   state_t             state_q;
   logic [TW-1:0]      timer_q;
   logic [2:0]         bit_idx_q;
   logic [7:0]         shreg_q;
   logic               par_q;
   logic               uarto_q;
   logic               busy_q;

   // waiti is registered, so a push never depends on the same-cycle pop.
   assign push = validi && !waiti_q;
   assign pop  = (state_q == S_IDLE) && (level_q != '0);
   assign head = mem_q[rd_ptr_q];

   // Next occupancy: simultaneous push and pop leave the level unchanged.
   always_comb begin
      level_d = level_q;
      if (push && !pop)
         level_d = level_q + 1'b1;
      else if (pop && !push)
         level_d = level_q - 1'b1;
   end

   // Byte storage write port; contents need no reset, only the pointers do.
   always_ff @(posedge clk) begin
      if (push && !srst)
         mem_q[wr_ptr_q] <= datai;
   end

   // Pointers, occupancy and the registered wait flag (held one extra cycle after reset).
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         waiti_q  <= 1'b1;
         recov_q  <= 1'b1;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
         recov_q <= 1'b0;
         waiti_q <= recov_q || (level_d == FULL_LVL);
      end
   end

   // Frame sequencer; uarto and busy are registered directly in the FSM.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         uarto_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               timer_q <= '0;
               uarto_q <= 1'b1;
               busy_q  <= 1'b0;
               if (level_q != '0) begin
                  shreg_q <= head;
                  // Parity is fixed at load time so it covers the original byte.
                  par_q   <= (PARITY == 1) ? ~^head : ^head;
                  uarto_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (timer_q == BIT_LAST) begin
                  timer_q   <= '0;
                  bit_idx_q <= '0;
                  uarto_q   <= shreg_q[0];
                  state_q   <= S_DATA;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_DATA: begin
               if (timer_q == BIT_LAST) begin
                  timer_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     if (PARITY != 0) begin
                        uarto_q <= par_q;
                        state_q <= S_PARITY;
                     end else begin
                        uarto_q <= 1'b1;
                        state_q <= S_STOP;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     shreg_q   <= shreg_q >> 1;
                     uarto_q   <= shreg_q[1];
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_PARITY: begin
               if (timer_q == BIT_LAST) begin
                  timer_q <= '0;
                  uarto_q <= 1'b1;
                  state_q <= S_STOP;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_STOP: begin
               if (timer_q == STOP_LAST) begin
                  timer_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: begin
               timer_q <= '0;
               uarto_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign waiti = waiti_q;
   assign uarto = uarto_q;
   assign level = level_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three transmitter variants (no parity / even / odd with two
// stop bits) checked every cycle against a queue-and-frame-position model.
module tb_uart_tx_fifo;

   localparam int P     = 4;
   localparam int NI    = 3;
   localparam int DEPTH = 16;

   logic       clk;
   logic       srst;
   logic [2:0] validi_w;
   logic [2:0] waiti_w;
   logic [2:0] uarto_w;
   logic [2:0] busy_w;
   logic [7:0] datai_w [NI];
   logic [4:0] level_w [NI];

   int n_chk;
   int n_pass;

   int par_c  [NI] = '{0, 2, 1};
   int stop_c [NI] = '{1, 1, 2};

   // Model state: byte queue, current frame byte and cycle position in frame.
   logic [7:0] fb     [NI][DEPTH];
   int         fcnt   [NI];
   logic       wait_m [NI];
   logic       recov_m[NI];
   logic       busy_m [NI];
   logic       line_m [NI];
   logic [7:0] cur_m  [NI];
   int         pos_m  [NI];
   bit         model_on;

   uart_tx_fifo #(.PULSEW(P), .FIFO_AW(4), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .srst(srst), .datai(datai_w[0]), .validi(validi_w[0]),
      .waiti(waiti_w[0]), .uarto(uarto_w[0]), .level(level_w[0]), .busy(busy_w[0]));
   uart_tx_fifo #(.PULSEW(P), .FIFO_AW(4), .PARITY(2), .STOP_BITS(1)) u1 (
      .clk(clk), .srst(srst), .datai(datai_w[1]), .validi(validi_w[1]),
      .waiti(waiti_w[1]), .uarto(uarto_w[1]), .level(level_w[1]), .busy(busy_w[1]));
   uart_tx_fifo #(.PULSEW(P), .FIFO_AW(4), .PARITY(1), .STOP_BITS(2)) u2 (
      .clk(clk), .srst(srst), .datai(datai_w[2]), .validi(validi_w[2]),
      .waiti(waiti_w[2]), .uarto(uarto_w[2]), .level(level_w[2]), .busy(busy_w[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Line value of frame bit idx: start, data LSB first, optional parity, stops.
   function automatic logic bit_val(input int i, input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (idx == 9 && par_c[i] != 0) return (par_c[i] == 2) ? ^b : ~^b;
      return 1'b1;
   endfunction

   function automatic int frame_len(input int i);
      return (9 + ((par_c[i] != 0) ? 1 : 0) + stop_c[i]) * P;
   endfunction

   task automatic model_step();
      logic push_m;
      for (int i = 0; i < NI; i++) begin
         if (srst) begin
            fcnt[i] = 0; busy_m[i] = 1'b0; line_m[i] = 1'b1;
            wait_m[i] = 1'b1; recov_m[i] = 1'b1; pos_m[i] = 0;
            model_on = 1'b1;
         end else begin
            push_m = validi_w[i] && !wait_m[i];
            if (busy_m[i]) begin
               pos_m[i]++;
               if (pos_m[i] == frame_len(i)) begin
                  busy_m[i] = 1'b0;
                  line_m[i] = 1'b1;
               end else begin
                  line_m[i] = bit_val(i, cur_m[i], pos_m[i] / P);
               end
            end else if (fcnt[i] > 0) begin
               cur_m[i] = fb[i][0];
               for (int k = 0; k < DEPTH-1; k++) fb[i][k] = fb[i][k+1];
               fcnt[i]--;
               busy_m[i] = 1'b1;
               pos_m[i]  = 0;
               line_m[i] = 1'b0;
            end else begin
               line_m[i] = 1'b1;
            end
            if (push_m) begin
               fb[i][fcnt[i]] = datai_w[i];
               fcnt[i]++;
            end
            wait_m[i]  = recov_m[i] || (fcnt[i] == DEPTH);
            recov_m[i] = 1'b0;
         end
      end
   endtask

   // Model advances on each rising edge; outputs compared mid-cycle.
   initial begin
      model_on = 1'b0;
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         if (model_on) begin
            for (int i = 0; i < NI; i++) begin
               chk($sformatf("u%0d_uarto", i), uarto_w[i], line_m[i]);
               chk($sformatf("u%0d_busy", i),  busy_w[i],  busy_m[i]);
               chk($sformatf("u%0d_level", i), level_w[i], fcnt[i]);
               chk($sformatf("u%0d_waiti", i), waiti_w[i], wait_m[i]);
            end
         end
      end
   end

   task automatic push(input int i, input logic [7:0] b);
      int t = 0;
      datai_w[i]  = b;
      validi_w[i] = 1'b1;
      while (waiti_w[i] !== 1'b0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("push_accept_in_time", (t < 500), 1);
      @(negedge clk);
      validi_w[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int t = 0;
      while (!(busy_w[i] === 1'b0 && level_w[i] === 5'd0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_in_time", (t < 3000), 1);
   endtask

   // Literal frame check; call at the negedge where the start bit first shows.
   task automatic expect_frame(input int i, input logic [7:0] b, input int has_par,
                               input logic pbit, input int nstop);
      logic bv [12];
      int   nb;
      for (int k = 0; k < 12; k++) bv[k] = 1'b1;
      nb    = 9 + has_par + nstop;
      bv[0] = 1'b0;
      for (int k = 0; k < 8; k++) bv[k+1] = b[k];
      if (has_par != 0) bv[9] = pbit;
      for (int c = 0; c < nb*P; c++) begin
         chk("lit_line", uarto_w[i], bv[c/P]);
         chk("lit_busy", busy_w[i], 1);
         @(negedge clk);
      end
      chk("lit_idle_busy", busy_w[i], 0);
      chk("lit_idle_line", uarto_w[i], 1);
   endtask

   initial begin
      int dens;
      n_chk = 0; n_pass = 0;
      srst = 1'b1; validi_w = '0;
      for (int i = 0; i < NI; i++) datai_w[i] = 8'h00;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk("rst_uarto", uarto_w[i], 1);
         chk("rst_busy",  busy_w[i],  0);
         chk("rst_level", level_w[i], 0);
         chk("rst_waiti", waiti_w[i], 1);
      end
      srst = 1'b0;
      @(negedge clk);
      chk("recov_waiti_hi", waiti_w[0], 1);
      @(negedge clk);
      chk("recov_waiti_lo", waiti_w[0], 0);

      // 0x55 into an idle block: line still high one cycle after the push.
      push(0, 8'h55);
      chk("lat_line_high", uarto_w[0], 1);
      @(negedge clk);
      expect_frame(0, 8'h55, 0, 1'b0, 1);

      // Even parity: 0x03 -> 0, 0x07 -> 1.
      push(1, 8'h03);
      @(negedge clk);
      expect_frame(1, 8'h03, 1, 1'b0, 1);
      push(1, 8'h07);
      @(negedge clk);
      expect_frame(1, 8'h07, 1, 1'b1, 1);

      // Odd parity with two stop bits, two queued bytes, one idle clock between.
      datai_w[2] = 8'h07; validi_w[2] = 1'b1;
      @(negedge clk);
      datai_w[2] = 8'h00;
      @(negedge clk);
      validi_w[2] = 1'b0;
      expect_frame(2, 8'h07, 1, 1'b0, 2);
      @(negedge clk);
      expect_frame(2, 8'h00, 1, 1'b1, 2);

      // Fill the FIFO behind a busy line, then hold a 17th byte until a pop.
      push(0, 8'hA0);
      for (int k = 0; k < 16; k++) push(0, 8'(k*17 + 3));
      chk("full_level", level_w[0], 16);
      chk("full_waiti", waiti_w[0], 1);
      push(0, 8'hEE);
      chk("refill_level", level_w[0], 16);
      wait_idle(0);

      // Push coinciding with the idle-cycle pop at level 3.
      push(0, 8'h11); push(0, 8'h12); push(0, 8'h13); push(0, 8'h14);
      begin
         int t = 0;
         while (busy_w[0] !== 1'b0 && t < 200) begin @(negedge clk); t++; end
         chk("pp_found_idle", (t < 200), 1);
      end
      chk("pp_level_before", level_w[0], 3);
      datai_w[0] = 8'h15; validi_w[0] = 1'b1;
      @(negedge clk);
      validi_w[0] = 1'b0;
      chk("pp_level_after", level_w[0], 3);
      chk("pp_busy", busy_w[0], 1);
      wait_idle(0);

      // Reset during data bit 3 with five bytes queued.
      push(0, 8'hC1);
      for (int k = 0; k < 5; k++) push(0, 8'(8'h30 + k));
      repeat (12) @(negedge clk);
      chk("mid_level", level_w[0], 5);
      chk("mid_bit3", uarto_w[0], 0);
      srst = 1'b1;
      @(negedge clk);
      chk("mid_rst_uarto", uarto_w[0], 1);
      chk("mid_rst_level", level_w[0], 0);
      chk("mid_rst_busy",  busy_w[0],  0);
      chk("mid_rst_waiti", waiti_w[0], 1);
      srst = 1'b0;
      @(negedge clk);
      chk("mid_recov_hi", waiti_w[0], 1);
      @(negedge clk);
      chk("mid_recov_lo", waiti_w[0], 0);
      repeat (60) @(negedge clk);
      chk("mid_no_frame_busy", busy_w[0], 0);
      chk("mid_no_frame_line", uarto_w[0], 1);

      // Randomized traffic with varying density and rare resets.
      for (int c = 0; c < 3000; c++) begin
         case ((c / 500) % 3)
            0:       dens = 10;
            1:       dens = 95;
            default: dens = 50;
         endcase
         srst = ($urandom_range(0, 599) == 0);
         for (int i = 0; i < NI; i++) begin
            validi_w[i] = ($urandom_range(0, 99) < dens);
            datai_w[i]  = 8'($urandom);
         end
         @(negedge clk);
      end
      srst = 1'b0; validi_w = '0;
      for (int i = 0; i < NI; i++) wait_idle(i);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
